// File: rtl/euler_integrator_if.sv
// Valid/ready handshake bundle for the Euler integrator: the sample comes in, the updated state goes out.
interface euler_integrator_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] pos_in;
    logic [WIDTH-1:0] vel_in;
    logic [WIDTH-1:0] acc_in;
    logic [WIDTH-1:0] dt_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] pos_out;
    logic [WIDTH-1:0] vel_out;
    logic             ovf;

    modport master (
        output in_valid, pos_in, vel_in, acc_in, dt_in, out_ready,
        input  in_ready, out_valid, pos_out, vel_out, ovf
    );

    modport slave (
        input  in_valid, pos_in, vel_in, acc_in, dt_in, out_ready,
        output in_ready, out_valid, pos_out, vel_out, ovf
    );
endinterface

// File: rtl/euler_integrator.sv
// Two-stage semi-implicit Euler step in signed Q-format: vel' = vel + acc*dt, pos' = pos + vel'*dt.
// Define SATURATE_EN for saturating arithmetic and a sticky ovf flag; otherwise arithmetic wraps and ovf is 0.
module euler_integrator #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned Q     = 16
) (
    input  logic                clk,
    input  logic                rst,
    euler_integrator_if.slave   bus
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned PW = 2 * WIDTH;
`ifdef SATURATE_EN
    localparam logic [W-1:0] MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
`endif

    // Returns {overflow, sum}.
    function automatic logic [W:0] fx_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] sum;
        logic         sat;
        sum = a + b;
`ifdef SATURATE_EN
        sat = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
        if (sat) sum = a[W-1] ? MIN_V : MAX_V;
`else
        sat = 1'b0;
`endif
        return {sat, sum};
    endfunction

    // Sign-magnitude multiply so truncation is toward zero; returns {overflow, product}.
    function automatic logic [W:0] fx_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic          neg;
        logic [W-1:0]  mag_a;
        logic [W-1:0]  mag_b;
        logic [W-1:0]  keep;
        logic [W-1:0]  res;
        logic [PW-1:0] prod;
        logic          sat;
        neg   = a[W-1] ^ b[W-1];
        mag_a = a[W-1] ? W'(~a + W'(1)) : a;
        mag_b = b[W-1] ? W'(~b + W'(1)) : b;
        prod  = PW'(mag_a) * PW'(mag_b);
        keep  = prod[W+Q-1:Q];
        res   = neg ? W'(~keep + W'(1)) : keep;
`ifdef SATURATE_EN
        // A negative result may reach exactly the most negative value; a positive one may not.
        sat = (|prod[PW-1:W+Q]) | (neg ? (keep[W-1] & (|keep[W-2:0])) : keep[W-1]);
        if (sat) res = neg ? MIN_V : MAX_V;
`else
        sat = 1'b0;
`endif
        return {sat, res};
    endfunction

    logic         s1_valid_q, s1_valid_d;
    logic [W-1:0] pos_s1_q,   pos_s1_d;
    logic [W-1:0] dt_s1_q,    dt_s1_d;
    logic [W-1:0] vel_s1_q,   vel_s1_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] pos_out_q,  pos_out_d;
    logic [W-1:0] vel_out_q,  vel_out_d;
    logic         ovf_q,      ovf_d;

    logic         adv1_c;
    logic         adv2_c;
    logic         in_ready_c;
    logic         accept_c;
    logic [W:0]   mul1_c;
    logic [W:0]   add1_c;
    logic [W:0]   mul2_c;
    logic [W:0]   add2_c;
    logic         s1_sat_c;
    logic         s2_sat_c;

    // Handshake, both arithmetic stages and next-state selection.
    always_comb begin
        adv2_c     = !out_valid_q || bus.out_ready;
        adv1_c     = !s1_valid_q || adv2_c;
        in_ready_c = adv1_c && !rst;
        accept_c   = bus.in_valid && in_ready_c;

        mul1_c = fx_mul(bus.acc_in, bus.dt_in);
        add1_c = fx_add(bus.vel_in, mul1_c[W-1:0]);
        mul2_c = fx_mul(vel_s1_q, dt_s1_q);
        add2_c = fx_add(pos_s1_q, mul2_c[W-1:0]);

        s1_valid_d  = s1_valid_q;
        pos_s1_d    = pos_s1_q;
        dt_s1_d     = dt_s1_q;
        vel_s1_d    = vel_s1_q;
        out_valid_d = out_valid_q;
        pos_out_d   = pos_out_q;
        vel_out_d   = vel_out_q;
        s1_sat_c    = 1'b0;
        s2_sat_c    = 1'b0;

        if (adv1_c) begin
            s1_valid_d = accept_c;
            if (accept_c) begin
                pos_s1_d = bus.pos_in;
                dt_s1_d  = bus.dt_in;
                vel_s1_d = add1_c[W-1:0];
                s1_sat_c = mul1_c[W] | add1_c[W];
            end
        end

        // Output regs only load a real sample, so an empty pipe holds the last result.
        if (adv2_c) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pos_out_d = add2_c[W-1:0];
                vel_out_d = vel_s1_q;
                s2_sat_c  = mul2_c[W] | add2_c[W];
            end
        end

        ovf_d = ovf_q | s1_sat_c | s2_sat_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            pos_s1_q    <= '0;
            dt_s1_q     <= '0;
            vel_s1_q    <= '0;
            out_valid_q <= 1'b0;
            pos_out_q   <= '0;
            vel_out_q   <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            pos_s1_q    <= pos_s1_d;
            dt_s1_q     <= dt_s1_d;
            vel_s1_q    <= vel_s1_d;
            out_valid_q <= out_valid_d;
            pos_out_q   <= pos_out_d;
            vel_out_q   <= vel_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.pos_out   = pos_out_q;
    assign bus.vel_out   = vel_out_q;
`ifdef SATURATE_EN
    assign bus.ovf       = ovf_q;
`else
    assign bus.ovf       = 1'b0;
`endif
endmodule
